conv_transposed_1d_zero_insert_feeder: RTL
==========================================

Name: conv_transposed_1d_zero_insert_feeder

Overview:
- Upstream stage for the 1D transposed-convolution datapath.
- Turns a frame of input samples into the stride-expanded, edge-padded stream that lets a transposed conv run as a direct dilated convolution.
- Inserts STRIDE-1 zeros between samples and EDGE zeros before the first and after the last sample of each frame.
- Uses valid/ready streaming on both sides, with one registered output stage.

Parameters:
- DATA_W, 32: sample width.
- KERNEL_SIZE, 3: taps of the downstream kernel.
- STRIDE, 2: transposed-conv stride, >=1.
- PADDING, 1: transposed-conv padding. Must satisfy 0 <= PADDING <= DILATION*(KERNEL_SIZE-1); violation is an elaboration error.
- DILATION, 2: tap spacing, >=1.
- EDGE (derived, localparam): DILATION*(KERNEL_SIZE-1) - PADDING. Equals 3 at defaults.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid && in_ready.
- in_data  in  DATA_W  input sample.
- in_last  in  1  marks the final sample of the frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  expanded stream sample.
- out_last  out  1  final sample of the expanded frame.
- busy  out  1  high from frame start until the out_last beat is accepted.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, counters=0, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=0.
- Output register update: adv = !out_valid || out_ready. The register loads only when adv=1. If adv=1 and no beat is produced, out_valid is cleared.
- in_ready = (state==DATA) && adv. This is combinational, with no dependence on in_valid.
- FSM:
  - IDLE: when in_valid=1, go to LEAD (EDGE>0) or DATA (EDGE=0) and set busy. No input is consumed here.
  - LEAD: emit zero per adv cycle; cnt counts 0..EDGE-1; then go to DATA.
  - DATA: on input handshake, emit in_data.
    - in_last=1: go to TRAIL (EDGE>0). If EDGE=0, set out_last on this beat and go to IDLE.
    - in_last=0: go to GAP (STRIDE>1) or stay in DATA (STRIDE=1).
  - GAP: emit STRIDE-1 zeros, then go to DATA.
  - TRAIL: emit EDGE zeros; out_last=1 on the last one; then go to IDLE.
- busy clears when the out_last beat is accepted (out_valid && out_ready && out_last).
- Output frame length for L inputs: (L-1)*STRIDE + 1 + 2*EDGE. This equals the transposed-conv output length plus DILATION*(KERNEL_SIZE-1).
- Backpressure: while out_valid && !out_ready, out_data, out_last and out_valid hold stable, and no state, counter or input handshake advances.
- Latency: an accepted input appears on out_data the next cycle.
- Throughput: 1 beat/cycle with out_ready held high.
- Single-sample frame (in_last on the first sample): EDGE zeros, sample, EDGE zeros. No GAP is emitted.
- Zeros are exact all-zero words. in_data is passed unmodified.
- in_valid dropping in DATA: nothing is emitted and no bubble zero is inserted. out_valid deasserts once the register drains.
- Back-to-back frames: a new frame may start in IDLE on the cycle after the last TRAIL beat is loaded.
- Reset mid-frame: the frame is abandoned; all outputs return to reset values immediately. No partial frame resumes.

Test Plan:
- Defaults (EDGE=3, STRIDE=2), frame 5,7,9 (last on 9), out_ready=1 → out_data 0,0,0,5,0,7,0,9,0,0,0 (11 beats); out_last only on beat 11; busy drops after it.
- Same frame, out_ready toggling 1,0 each cycle → identical 11-beat sequence; outputs stable during stalls; in_ready never high while out_valid && !out_ready.
- Single sample 0xDEADBEEF with last → 0,0,0,0xDEADBEEF,0,0,0; out_last on the 7th beat; no gap zero.
- Params STRIDE=1, KERNEL_SIZE=2, DILATION=1, PADDING=1 (EDGE=0), frame 1,2,3 → 1,2,3; out_last on 3; LEAD, GAP and TRAIL never entered.
- in_valid low for 4 cycles between samples 5 and 7 → still 0,0,0,5,0,7,…; no extra zeros; out_valid low during the starvation.
- rst_n asserted during the GAP after sample 5, released, then frame 1,2 → out_valid/out_last/busy are 0 during reset; the new frame yields 0,0,0,1,0,2,0,0,0 with nothing from the old frame.

Source files
------------

// File: rtl/conv_transposed_1d_zero_insert_feeder.sv
// ============================================================================
// conv_transposed_1d_zero_insert_feeder
//   Stride-expands and edge-pads an input frame so a transposed 1D conv can run
//   as a direct dilated convolution. Revision: 1.0
// ============================================================================
`default_nettype none

module conv_transposed_1d_zero_insert_feeder #(
  parameter int DATA_W      = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 2,
  parameter int PADDING     = 1,
  parameter int DILATION    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int EDGE      = DILATION * (KERNEL_SIZE - 1) - PADDING;
  localparam int C_CNT_MAX = (EDGE > STRIDE) ? EDGE : STRIDE;
  localparam int CNT_W     = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] C_EDGE_LAST = CNT_W'((EDGE > 0) ? EDGE - 1 : 0);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'((STRIDE > 1) ? STRIDE - 2 : 0);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  if (PADDING < 0 || PADDING > DILATION * (KERNEL_SIZE - 1)) begin : g_bad_padding
    $error("PADDING must lie in [0, DILATION*(KERNEL_SIZE-1)]");
  end
  if (STRIDE < 1 || DILATION < 1 || KERNEL_SIZE < 1) begin : g_bad_geometry
    $error("STRIDE, DILATION and KERNEL_SIZE must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_DATA  = 3'd2,
    S_GAP   = 3'd3,
    S_TRAIL = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic              w_adv;

  // The output register may take a new beat when it is empty or being drained.
  assign w_adv     = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_DATA) && w_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (out_valid_q && out_ready && out_last_q) begin
        busy_q <= 1'b0;
      end
      if (w_adv) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        case (state_q)
          S_IDLE: begin
            // A pending sample only opens the frame; it is consumed in DATA.
            if (in_valid) begin
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= (EDGE > 0) ? S_LEAD : S_DATA;
            end
          end
          S_LEAD: begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            if (cnt_q == C_EDGE_LAST) begin
              cnt_q   <= '0;
              state_q <= S_DATA;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          S_DATA: begin
            if (in_valid) begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              cnt_q       <= '0;
              if (in_last) begin
                if (EDGE > 0) begin
                  state_q <= S_TRAIL;
                end else begin
                  out_last_q <= 1'b1;
                  state_q    <= S_IDLE;
                end
              end else if (STRIDE > 1) begin
                state_q <= S_GAP;
              end
            end
          end
          S_GAP: begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            if (cnt_q == C_GAP_LAST) begin
              cnt_q   <= '0;
              state_q <= S_DATA;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          S_TRAIL: begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            if (cnt_q == C_EDGE_LAST) begin
              out_last_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
